// File: rtl/lc_arb_pkg.sv
// lc_arb_pkg: shared types and constants for the LLC port arbiter.
package lc_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DELIVER} lc_arb_state_t;
    typedef enum logic {REQ_I, REQ_D} lc_req_id_t;
    localparam int LC_LINE_BITS = 512;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with its priority register.
module rr_arbiter2
    import lc_arb_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       en,
    output logic [1:0] grant
);
    lc_req_id_t prio;
    assign grant = en ? {req[1] & (~req[0] | (prio == REQ_D)),
                         req[0] & (~req[1] | (prio == REQ_I))} : 2'b00;
    // After a grant the other requester takes priority.
    always_ff @(posedge clk_in) begin
        if (rst_in) prio <= REQ_I;
        else if (advance) prio <= grant[0] ? REQ_D : REQ_I;
    end
endmodule

// File: rtl/lc_arbiter.sv
// lc_arbiter: shares the LLC/DIMM port between L1I and L1D, one transaction at a time,
// round-robin grant, response routed to its owner, squashed I fills discarded.
module lc_arbiter
    import lc_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BITS  = LC_LINE_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush_i_in,
    input  logic                  i_valid_in,
    input  logic                  d_valid_in,
    output logic                  i_ready_out,
    output logic                  d_ready_out,
    input  logic [ADDR_WIDTH-1:0] i_addr_in,
    input  logic [ADDR_WIDTH-1:0] d_addr_in,
    input  logic [LINE_BITS-1:0]  i_value_in,
    input  logic [LINE_BITS-1:0]  d_value_in,
    input  logic                  i_we_in,
    input  logic                  d_we_in,
    output logic                  i_valid_out,
    output logic                  d_valid_out,
    input  logic                  i_ready_in,
    input  logic                  d_ready_in,
    output logic [ADDR_WIDTH-1:0] i_addr_out,
    output logic [ADDR_WIDTH-1:0] d_addr_out,
    output logic [LINE_BITS-1:0]  i_value_out,
    output logic [LINE_BITS-1:0]  d_value_out,
    output logic                  mem_valid_out,
    input  logic                  mem_ready_in,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [LINE_BITS-1:0]  mem_value_out,
    output logic                  mem_we_out,
    input  logic                  mem_valid_in,
    output logic                  mem_ready_out,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [LINE_BITS-1:0]  mem_value_in,
    output logic                  err_out
);
    lc_arb_state_t state, state_next;
    lc_req_id_t owner;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_BITS-1:0] line;
    logic we, drop;
    logic [1:0] grant;
    logic flush_own, owner_ready, deliver;

    rr_arbiter2 u_rr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .req    ({d_valid_in, i_valid_in & ~flush_i_in}),
        .advance(|grant),
        .en     (state == IDLE && !rst_in),
        .grant  (grant)
    );

    assign flush_own   = flush_i_in && owner == REQ_I;
    assign owner_ready = owner == REQ_I ? i_ready_in : d_ready_in;
    assign deliver     = state == DELIVER && !flush_own;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = |grant ? REQ : IDLE;
            REQ:       state_next = mem_ready_in ? (we ? IDLE : WAIT_RESP) : REQ;
            WAIT_RESP: state_next = mem_valid_in ? ((drop || flush_own) ? IDLE : DELIVER) : WAIT_RESP;
            default:   state_next = (owner_ready || flush_own) ? IDLE : DELIVER;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            owner <= REQ_I;
            addr  <= '0;
            line  <= '0;
            we    <= 1'b0;
            drop  <= 1'b0;
            err_out <= 1'b0;
        end else begin
            state <= state_next;
            if (|grant) begin
                owner <= grant[1] ? REQ_D : REQ_I;
                addr  <= grant[1] ? d_addr_in : i_addr_in;
                line  <= grant[1] ? d_value_in : i_value_in;
                we    <= grant[1] ? d_we_in : i_we_in;
                drop  <= 1'b0;
            end
            if ((state == REQ || state == WAIT_RESP) && flush_own) drop <= 1'b1;
            // The write data register is reused to hold the returning line.
            if (state == WAIT_RESP && mem_valid_in) begin
                line <= mem_value_in;
                if (mem_addr_in != addr) err_out <= 1'b1;
            end
        end
    end

    assign i_ready_out   = grant[0];
    assign d_ready_out   = grant[1];
    assign i_valid_out   = deliver && owner == REQ_I;
    assign d_valid_out   = deliver && owner == REQ_D;
    assign i_addr_out    = addr;
    assign d_addr_out    = addr;
    assign i_value_out   = line;
    assign d_value_out   = line;
    assign mem_valid_out = state == REQ;
    assign mem_addr_out  = addr;
    assign mem_value_out = line;
    assign mem_we_out    = we;
    assign mem_ready_out = state == WAIT_RESP;
endmodule

// File: tb/tb_lc_arbiter.sv
// tb_lc_arbiter: grant table, directed corner sequences and a randomized run against a reference model.
`timescale 1ns/1ps
module tb_lc_arbiter;
    localparam int AW = 64;
    localparam int LW = 512;
    logic clk = 1'b0;
    logic rst_in, flush_i_in, i_valid_in, d_valid_in, i_we_in, d_we_in, i_ready_in, d_ready_in;
    logic mem_ready_in, mem_valid_in;
    logic [AW-1:0] i_addr_in, d_addr_in, mem_addr_in;
    logic [LW-1:0] i_value_in, d_value_in, mem_value_in;
    logic i_ready_out, d_ready_out, i_valid_out, d_valid_out, mem_valid_out, mem_ready_out, mem_we_out, err_out;
    logic [AW-1:0] i_addr_out, d_addr_out, mem_addr_out;
    logic [LW-1:0] i_value_out, d_value_out, mem_value_out;
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    lc_arbiter dut (
        .clk_in(clk), .rst_in(rst_in), .flush_i_in(flush_i_in),
        .i_valid_in(i_valid_in), .d_valid_in(d_valid_in),
        .i_ready_out(i_ready_out), .d_ready_out(d_ready_out),
        .i_addr_in(i_addr_in), .d_addr_in(d_addr_in),
        .i_value_in(i_value_in), .d_value_in(d_value_in),
        .i_we_in(i_we_in), .d_we_in(d_we_in),
        .i_valid_out(i_valid_out), .d_valid_out(d_valid_out),
        .i_ready_in(i_ready_in), .d_ready_in(d_ready_in),
        .i_addr_out(i_addr_out), .d_addr_out(d_addr_out),
        .i_value_out(i_value_out), .d_value_out(d_value_out),
        .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
        .mem_addr_out(mem_addr_out), .mem_value_out(mem_value_out), .mem_we_out(mem_we_out),
        .mem_valid_in(mem_valid_in), .mem_ready_out(mem_ready_out),
        .mem_addr_in(mem_addr_in), .mem_value_in(mem_value_in),
        .err_out(err_out)
    );

    logic [13:0] all_outs;
    assign all_outs = {i_ready_out, d_ready_out, i_valid_out, d_valid_out, mem_valid_out, mem_ready_out,
                       mem_we_out, err_out, |i_addr_out, |d_addr_out, |i_value_out, |d_value_out,
                       |mem_addr_out, |mem_value_out};

    typedef struct {logic iv, dv, fl, ir, dr;} gvec_t;
    gvec_t tbl[6];

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {flush_i_in, i_valid_in, d_valid_in, i_we_in, d_we_in, i_ready_in, d_ready_in, mem_ready_in, mem_valid_in} = '0;
        i_addr_in = '0; d_addr_in = '0; mem_addr_in = '0;
        i_value_in = '0; d_value_in = '0; mem_value_in = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        clear_inputs();
        cyc();
        rst_in = 1'b0;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model state: transaction phase 0 idle, 1 request, 2 awaiting response, 3 delivering.
    int m_phase, m_owner, m_prio, resp_cnt;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;
    logic m_we, m_drop, m_err;

    initial begin
        logic [LW-1:0] line_a;
        int n;
        rst_in = 1'b1;
        clear_inputs();
        i_valid_in = 1'b1;
        d_valid_in = 1'b1;
        cyc();
        chk("reset_outs", all_outs, 0);
        rst_in = 1'b0;
        clear_inputs();

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 0, 1};
        tbl[3] = '{1, 1, 0, 1, 0};
        tbl[4] = '{1, 0, 1, 0, 0};
        tbl[5] = '{0, 1, 1, 0, 1};
        for (int k = 0; k < 6; k++) begin
            i_valid_in = tbl[k].iv;
            d_valid_in = tbl[k].dv;
            flush_i_in = tbl[k].fl;
            #1;
            chk($sformatf("grant_tbl%0d", k), {i_ready_out, d_ready_out}, {tbl[k].ir, tbl[k].dr});
        end
        clear_inputs();

        // I read at 0x1000, response three cycles after mem_ready_out rises.
        do_reset();
        line_a = rand_line();
        i_valid_in = 1'b1;
        i_addr_in = 64'h1000;
        #1 chk("iread_ready", i_ready_out, 1);
        cyc();
        i_valid_in = 1'b0;
        mem_ready_in = 1'b1;
        #1 chk("iread_memreq", {mem_valid_out, mem_we_out, mem_addr_out}, {2'b10, 64'h1000});
        cyc();
        mem_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("iread_wait", {mem_ready_out, mem_valid_out, i_valid_out}, 3'b100);
            cyc();
        end
        mem_valid_in = 1'b1;
        mem_addr_in = 64'h1000;
        mem_value_in = line_a;
        #1 chk("iread_resp_rdy", mem_ready_out, 1);
        cyc();
        mem_valid_in = 1'b0;
        i_ready_in = 1'b1;
        #1 chk("iread_valid", {i_valid_out, d_valid_out, err_out}, 3'b100);
        chk("iread_value", i_value_out, line_a);
        chk("iread_addr", i_addr_out, 64'h1000);
        cyc();
        i_ready_in = 1'b0;
        #1 chk("iread_done", {i_valid_out, mem_valid_out, mem_ready_out}, 0);

        // Contention: back-to-back writes with both requesters always valid.
        do_reset();
        {i_valid_in, d_valid_in, i_we_in, d_we_in, mem_ready_in} = '1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_onehot", i_ready_out & d_ready_out, 0);
            if (i_ready_out | d_ready_out) begin
                chk($sformatf("rr_grant%0d", n), d_ready_out, n % 2);
                n++;
            end
            cyc();
        end
        chk("rr_count", n, 4);
        clear_inputs();

        // D writeback with memory stalled five cycles.
        do_reset();
        line_a = rand_line();
        d_valid_in = 1'b1;
        d_we_in = 1'b1;
        d_addr_in = 64'hDEAD_0040;
        d_value_in = line_a;
        #1 chk("dwb_ready", d_ready_out, 1);
        cyc();
        d_valid_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_ready_in = (k == 5);
            #1 chk("dwb_req", {mem_valid_out, mem_we_out, mem_addr_out}, {2'b11, 64'hDEAD_0040});
            chk("dwb_data", mem_value_out, line_a);
            cyc();
        end
        mem_ready_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 chk("dwb_idle", {mem_valid_out, mem_ready_out, d_valid_out, i_valid_out}, 0);
            cyc();
        end

        // Flush during WAIT_RESP of an I read.
        do_reset();
        i_valid_in = 1'b1;
        i_addr_in = 64'h3000;
        cyc();
        i_valid_in = 1'b0;
        mem_ready_in = 1'b1;
        cyc();
        mem_ready_in = 1'b0;
        flush_i_in = 1'b1;
        #1 chk("fl_wait", mem_ready_out, 1);
        cyc();
        flush_i_in = 1'b0;
        mem_valid_in = 1'b1;
        mem_addr_in = 64'h3000;
        mem_value_in = rand_line();
        #1 chk("fl_consume", {mem_ready_out, i_valid_out}, 2'b10);
        cyc();
        mem_valid_in = 1'b0;
        d_valid_in = 1'b1;
        d_we_in = 1'b1;
        #1 chk("fl_next_grant", {i_valid_out, d_ready_out}, 2'b01);
        cyc();
        d_valid_in = 1'b0;
        #1 chk("fl_no_ivalid", i_valid_out, 0);

        // Response address mismatch on a D read.
        do_reset();
        line_a = rand_line();
        d_valid_in = 1'b1;
        d_addr_in = 64'h2000;
        cyc();
        d_valid_in = 1'b0;
        mem_ready_in = 1'b1;
        cyc();
        mem_ready_in = 1'b0;
        mem_valid_in = 1'b1;
        mem_addr_in = 64'h2040;
        mem_value_in = line_a;
        #1 chk("mm_err_before", err_out, 0);
        cyc();
        mem_valid_in = 1'b0;
        d_ready_in = 1'b1;
        #1 chk("mm_deliver", {err_out, d_valid_out, i_valid_out}, 3'b110);
        chk("mm_addr", d_addr_out, 64'h2000);
        chk("mm_value", d_value_out, line_a);
        cyc();
        d_ready_in = 1'b0;
        cyc();
        chk("mm_sticky", err_out, 1);

        // Reset in the middle of a transaction.
        do_reset();
        i_valid_in = 1'b1;
        i_addr_in = 64'h4000;
        cyc();
        #1 chk("rst_mid_req", mem_valid_out, 1);
        rst_in = 1'b1;
        d_valid_in = 1'b1;
        cyc();
        chk("rst_mid_outs", all_outs, 0);
        rst_in = 1'b0;
        #1 chk("rst_mid_grant", {i_ready_out, d_ready_out}, 2'b10);

        // Randomized traffic against the reference model.
        do_reset();
        m_phase = 0; m_owner = 0; m_prio = 0; resp_cnt = -1;
        m_addr = '0; m_data = '0; m_we = 0; m_drop = 0; m_err = 0;
        for (int c = 0; c < 4000; c++) begin
            logic e_ir, e_dr, fl;
            i_valid_in = $urandom_range(0, 1);
            d_valid_in = $urandom_range(0, 1);
            i_we_in = ($urandom_range(0, 3) == 0);
            d_we_in = ($urandom_range(0, 2) == 0);
            i_addr_in = {$urandom, $urandom};
            d_addr_in = {$urandom, $urandom};
            i_value_in = rand_line();
            d_value_in = rand_line();
            i_ready_in = $urandom_range(0, 1);
            d_ready_in = $urandom_range(0, 1);
            mem_ready_in = $urandom_range(0, 1);
            flush_i_in = (m_phase != 0) && ($urandom_range(0, 5) == 0);
            mem_valid_in = (resp_cnt == 0);
            mem_addr_in = ($urandom_range(0, 15) == 0) ? m_addr ^ 64'h40 : m_addr;
            mem_value_in = rand_line();
            fl = flush_i_in && m_owner == 0;
            e_ir = m_phase == 0 && i_valid_in && !flush_i_in && (!d_valid_in || m_prio == 0);
            e_dr = m_phase == 0 && d_valid_in && (!(i_valid_in && !flush_i_in) || m_prio == 1);
            #1;
            chk("rnd_ctl", {i_ready_out, d_ready_out, i_valid_out, d_valid_out, mem_valid_out, mem_ready_out, err_out},
                {e_ir, e_dr, m_phase == 3 && m_owner == 0 && !fl, m_phase == 3 && m_owner == 1,
                 m_phase == 1, m_phase == 2, m_err});
            if (m_phase == 1) begin
                chk("rnd_mem_addr", {mem_we_out, mem_addr_out}, {m_we, m_addr});
                chk("rnd_mem_value", mem_value_out, m_data);
            end
            if (m_phase == 3) begin
                chk("rnd_resp_addr", m_owner == 0 ? i_addr_out : d_addr_out, m_addr);
                chk("rnd_resp_value", m_owner == 0 ? i_value_out : d_value_out, m_data);
            end
            if (resp_cnt > 0) resp_cnt--;
            case (m_phase)
                0: if (e_ir || e_dr) begin
                    m_owner = e_dr ? 1 : 0;
                    m_addr = e_dr ? d_addr_in : i_addr_in;
                    m_data = e_dr ? d_value_in : i_value_in;
                    m_we = e_dr ? d_we_in : i_we_in;
                    m_drop = 0;
                    m_prio = 1 - m_owner;
                    m_phase = 1;
                end
                1: begin
                    if (fl) m_drop = 1;
                    if (mem_ready_in) begin
                        m_phase = m_we ? 0 : 2;
                        if (!m_we) resp_cnt = $urandom_range(0, 3);
                    end
                end
                2: begin
                    if (fl) m_drop = 1;
                    if (mem_valid_in) begin
                        m_data = mem_value_in;
                        if (mem_addr_in != m_addr) m_err = 1;
                        m_phase = m_drop ? 0 : 3;
                        resp_cnt = -1;
                    end
                end
                default: if (fl || (m_owner == 0 ? i_ready_in : d_ready_in)) m_phase = 0;
            endcase
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
